// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one slow combinational ALU
// Round-robin grant in IDLE, fixed settle wait, then a one-cycle response pulse to the owner.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic        r_ptr;
    logic        r_owner;
    logic [3:0]  r_cnt;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic [31:0] r_resp_result;
    logic        r_resp_zero;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic        r_busy;

    logic w_idle;
    logic w_gnt1;
    logic w_xfer0;
    logic w_xfer1;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign w_idle     = rst_n & (r_state == ST_IDLE);
    assign w_gnt1     = req1_valid & (~req0_valid | r_ptr);
    assign req0_ready = w_idle & req0_valid & ~w_gnt1;
    assign req1_ready = w_idle & w_gnt1;
    assign w_xfer0    = req0_valid & req0_ready;
    assign w_xfer1    = req1_valid & req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 1'b0;
            r_owner       <= 1'b0;
            r_cnt         <= 4'd0;
            r_alu_a       <= 32'd0;
            r_alu_b       <= 32'd0;
            r_alu_op      <= 3'd0;
            r_resp_result <= 32'd0;
            r_resp_zero   <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer0 || w_xfer1) begin
                        r_alu_a  <= w_xfer1 ? req1_a  : req0_a;
                        r_alu_b  <= w_xfer1 ? req1_b  : req0_b;
                        r_alu_op <= w_xfer1 ? req1_op : req0_op;
                        r_owner  <= w_xfer1;
                        r_ptr    <= ~w_xfer1;
                        r_cnt    <= CNT_INIT;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_result <= alu_result;
                        r_resp_zero   <= alu_zero;
                        r_resp0_valid <= ~r_owner;
                        r_resp1_valid <= r_owner;
                        r_state       <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (SETTLE_CYCLES=4 and 1)
// A reference arbiter model predicts grants and responses; a negedge monitor compares.
module tb_alu_arbiter;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp_zero, busy;
    logic [31:0] resp_result, alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero;

    logic        s_v = 1'b0;
    logic [31:0] s_a = '0, s_b = '0;
    logic [2:0]  s_op = '0;
    logic        s_ready, s_r1_ready, s_resp0, s_resp1, s_zero, s_busy;
    logic [31:0] s_res, s_alu_a, s_alu_b, s_alu_result;
    logic [2:0]  s_alu_op;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result   = alu_ref(alu_a, alu_b, alu_op);
    assign alu_zero     = (alu_result == 32'd0);
    assign s_alu_result = alu_ref(s_alu_a, s_alu_b, s_alu_op);

    alu_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    alu_arbiter #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_v), .req0_a(s_a), .req0_b(s_b), .req0_op(s_op), .req0_ready(s_ready),
        .req1_valid(1'b0), .req1_a(32'd0), .req1_b(32'd0), .req1_op(3'd0), .req1_ready(s_r1_ready),
        .resp0_valid(s_resp0), .resp1_valid(s_resp1), .resp_result(s_res), .resp_zero(s_zero),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .alu_result(s_alu_result),
        .alu_zero(s_alu_result == 32'd0), .busy(s_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: pending responses in transfer order plus arbiter bookkeeping.
    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        z;
        int          due;
    } exp_t;
    exp_t q[$];
    int   next_free = 0, last_xfer = 0, g;
    bit   ptr = 0;
    logic [31:0] ea = '0, eb = '0, er = '0, ga, gb;
    logic [2:0]  eop = '0, gop;
    logic        ez = 1'b0;
    logic [31:0] gr;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ready_in_reset", {62'd0, req0_ready, req1_ready}, 64'd0);
            q.delete();
            ptr = 0; next_free = cyc + 1; last_xfer = cyc;
            ea = '0; eb = '0; eop = '0; er = '0; ez = 1'b0;
        end else begin
            chk("busy", {63'd0, busy}, {63'd0, (cyc > last_xfer && cyc < next_free)});
            chk("alu_a", {32'd0, alu_a}, {32'd0, ea});
            chk("alu_b", {32'd0, alu_b}, {32'd0, eb});
            chk("alu_op", {61'd0, alu_op}, {61'd0, eop});
            chk("resp0_valid", {63'd0, resp0_valid},
                {63'd0, (q.size() > 0 && q[0].due == cyc && q[0].idx == 0)});
            chk("resp1_valid", {63'd0, resp1_valid},
                {63'd0, (q.size() > 0 && q[0].due == cyc && q[0].idx == 1)});
            if (q.size() > 0 && q[0].due == cyc) begin
                er = q[0].res; ez = q[0].z;
                void'(q.pop_front());
            end
            chk("resp_result", {32'd0, resp_result}, {32'd0, er});
            chk("resp_zero", {63'd0, resp_zero}, {63'd0, ez});
            g = -1;
            if (cyc >= next_free) begin
                if (req0_valid && req1_valid) g = ptr ? 1 : 0;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            chk("ready", {62'd0, req0_ready, req1_ready},
                {62'd0, (g == 0), (g == 1)});
            if (g >= 0) begin
                ga = g ? req1_a : req0_a; gb = g ? req1_b : req0_b; gop = g ? req1_op : req0_op;
                gr = alu_ref(ga, gb, gop);
                q.push_back('{g, gr, (gr == 32'd0), cyc + S + 1});
                ea = ga; eb = gb; eop = gop;
                ptr = (g == 0);
                last_xfer = cyc; next_free = cyc + S + 2;
            end
        end
    end

    task automatic drive(input int ch, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bit done = 0;
        int n = 0;
        if (ch == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        else         begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        while (!done && n < 200) begin
            @(negedge clk);
            if ((ch == 0) ? req0_ready : req1_ready) done = 1;
            n++;
        end
        @(posedge clk); #1;
        if (ch == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("drive_handshake", {63'd0, done}, 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int rq[$];
    int last_rdy, nxf, mode, k;
    logic [31:0] ra, rb;

    initial begin
        do_reset();
        drive(0, 32'd5, 32'd3, 3'd2);
        repeat (8) @(posedge clk);
        #1 do_reset();
        // Two simultaneous pairs: grants must alternate 0,1,0,1.
        repeat (2) begin
            fork
                drive(0, 32'd100, 32'd1, 3'd2);
                drive(1, 32'd200, 32'd50, 3'd6);
            join
        end
        drive(1, 32'd7, 32'd7, 3'd6);
        drive(0, 32'd11, 32'd22, 3'd1);
        repeat (3) begin
            req0_a = $urandom; req1_valid = ~req1_valid;
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 drive(0, 32'd9, 32'd4, 3'd2);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1, 32'hFFFF_0000, 32'h0000_FFFF, 3'd0);
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if (mode == 2) begin
                fork
                    drive(0, ra, rb, 3'($urandom_range(0, 7)));
                    drive(1, rb, ra, 3'($urandom_range(0, 7)));
                join
            end else begin
                drive(mode, ra, rb, 3'($urandom_range(0, 7)));
            end
            k = $urandom_range(0, 3);
            repeat (k) @(posedge clk);
            #1;
        end
        repeat (12) @(posedge clk);
        #1 chk("queue_drained", 64'(q.size()), 64'd0);

        // SETTLE_CYCLES=1 instance: held request accepted every 3 cycles, response 2 cycles after transfer.
        s_a = 32'd100; s_b = 32'd23; s_op = 3'd2; s_v = 1'b1;
        nxf = 0; last_rdy = 0;
        repeat (16) begin
            @(negedge clk);
            if (s_ready) begin
                if (nxf > 0) chk("s1_gap", 64'(cyc - last_rdy), 64'd3);
                last_rdy = cyc; rq.push_back(cyc); nxf++;
            end
            if (s_resp0) begin
                chk("s1_resp_pending", {63'd0, (rq.size() > 0)}, 64'd1);
                if (rq.size() > 0) chk("s1_latency", 64'(cyc - rq.pop_front()), 64'd2);
                chk("s1_result", {32'd0, s_res}, 64'd123);
            end
        end
        @(posedge clk); #1 s_v = 1'b0;
        chk("s1_count", {63'd0, (nxf >= 5)}, 64'd1);
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, clock cycles allowed for the gate-level ALU outputs to settle after operands change; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-006 req0_op  input  3  requester 0 ALU control code, passed through unmodified.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_op, req1_ready  same widths and meanings for requester 1.
REQ-009 resp0_valid, resp1_valid  output  1 each  one-cycle pulse: result for that requester is on resp_result/resp_zero.
REQ-010 resp_result  output  32  captured ALU result; resp_zero  output  1  captured ALU zero flag.
REQ-011 alu_a, alu_b  output  32 each; alu_op  output  3  registered drive to the shared ALU.
REQ-012 alu_result  input  32; alu_zero  input  1  shared ALU outputs.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, SETTLE, RESP; exactly one active.
REQ-015 reqN_ready combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-016 Transfer occurs when reqN_valid and reqN_ready high in the same cycle; requesters hold valid, operands, op stable until transfer.
REQ-017 Grant in IDLE: only one valid -> that requester; both valid -> requester holding priority pointer; none valid -> stay IDLE, no ready.
REQ-018 Priority pointer flips to the non-granted requester on every transfer; unchanged otherwise.
REQ-019 On transfer: alu_a/alu_b/alu_op load granted operands, owner register records granted index, settle counter loads SETTLE_CYCLES-1, next state SETTLE.
REQ-020 alu_a/alu_b/alu_op stay constant from transfer edge until next transfer or reset.
REQ-021 SETTLE: counter decrements each cycle; in the cycle counter equals 0, resp_result/resp_zero capture alu_result/alu_zero and next state RESP.
REQ-022 SETTLE lasts exactly SETTLE_CYCLES cycles; SETTLE_CYCLES=1 gives one SETTLE cycle.
REQ-023 RESP: respN_valid high for owner only, exactly one cycle; next state IDLE.
REQ-024 Latency: transfer in cycle T -> respN_valid high in cycle T+SETTLE_CYCLES+1; next transfer possible in T+SETTLE_CYCLES+2.
REQ-025 resp_result/resp_zero hold last captured value until next capture.
REQ-026 reqN_valid changes during SETTLE/RESP ignored; no ready asserted outside IDLE.
REQ-027 No response backpressure; resp pulse is not repeated.

Reset
REQ-028 rst_n low at a rising edge, in any state: state IDLE, pointer favours requester 0, counter 0, owner 0.
REQ-029 Reset values: alu_a, alu_b, resp_result = 0; alu_op = 0; resp_zero, resp0_valid, resp1_valid, busy = 0; readies 0 while rst_n low.
REQ-030 Reset during SETTLE or RESP discards the operation; no resp pulse issued for it afterwards.

Verification
REQ-031 Single request, SETTLE_CYCLES=4: req0 a=5 b=3 op=2, ALU model returns a+b -> req0_ready in T, resp0_valid only in T+5, resp_result=8, resp_zero=0.
REQ-032 Simultaneous requests after reset: both valid -> req0 granted first, req1 granted at T+6; resp1_valid at T+11; next simultaneous pair grants req1 first only if pointer rule says so (checks alternation over 4 ops: 0,1,0,1).
REQ-033 Zero flag: req1 a=7 b=7 op=6 (subtract model) -> resp1_valid with resp_result=0, resp_zero=1; resp0_valid stays 0.
REQ-034 Operand stability: change req0_a during SETTLE and toggle req1_valid -> alu_a unchanged, no ready, busy=1 throughout SETTLE and RESP.
REQ-035 Reset mid-op: rst_n low for one edge at T+2 of a transfer -> next cycle IDLE, all outputs at reset values, no resp pulse for the aborted op; fresh request then completes normally.
REQ-036 SETTLE_CYCLES=1 build: transfer in T -> resp in T+2, back-to-back requests accepted every 3 cycles.
